// File: rtl/mac_pkg.sv
// Shared constants, state encoding and status-word layout for the MAC receive path.
// Consumers: mac_rx, mac_crc32_serial (CRC built only with MAC_RX_CRC_EN).
package mac_pkg;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  localparam int LEN_LSB  = 0;
  localparam int LEN_MSB  = 11;
  localparam int OVF_BIT  = 12;
  localparam int CRC_BIT  = 13;
  localparam int DRIB_BIT = 14;

  typedef enum logic [2:0] {IDLE, HUNT, DATA, FLUSH, STATUS, HOLD} rx_state_e;

  function automatic logic [31:0] status_word(input logic [11:0] len, input logic ovf,
                                              input logic crc_err, input logic drib);
    logic [31:0] s;
    s                  = '0;
    s[LEN_MSB:LEN_LSB] = len;
    s[OVF_BIT]         = ovf;
    s[CRC_BIT]         = crc_err;
    s[DRIB_BIT]        = drib;
    return s;
  endfunction

endpackage

// File: rtl/mac_crc32_serial.sv
// Bit-serial CRC-32 (Ethernet polynomial), one data bit per enabled cycle, LSB-first stream.
module mac_crc32_serial
  import mac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] crc
);

  logic fb;
  assign fb = crc[31] ^ bit_in;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    crc <= CRC_INIT;
    else if (clr)  crc <= CRC_INIT;
    else if (en)   crc <= {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  end

endmodule

// File: rtl/mac_rx.sv
// Ethernet MAC receive path: SFD hunt, LSB-first word packing into the RX buffer, status word 0.
// Optional CRC-32 check of the stored frame when MAC_RX_CRC_EN is defined.
module mac_rx
  import mac_pkg::*;
#(
  parameter int MAX_BYTES = 1536,
  parameter int ADDR_W    = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv,
  input  logic              rxd,
  input  logic              rx_bit_stb,
  input  logic              rx_release,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              rxfull,
  output logic              rx_busy,
  output logic [7:0]        drop_cnt
);

  localparam int                CNT_W    = 15;
  localparam logic [CNT_W-1:0]  MAX_BITS = CNT_W'(MAX_BYTES * 8);

  rx_state_e         state;
  logic              dv_q;
  logic [7:0]        sr;
  logic [CNT_W-1:0]  bitcnt;
  logic [31:0]       word;
  logic              ovf;

  logic              rise;
  logic [7:0]        sr_nxt;
  logic              store;
  logic              crc_err;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       status;

  assign rise      = rx_dv & ~dv_q;
  assign sr_nxt    = {rxd, sr[7:1]};
  assign store     = (state == DATA) && rx_bit_stb && (bitcnt < MAX_BITS);
  assign word_addr = ADDR_W'(bitcnt[CNT_W-2:5]) + ADDR_W'(1);
  assign status    = status_word(bitcnt[CNT_W-1:3], ovf, crc_err, bitcnt[2:0] != 3'd0);

`ifdef MAC_RX_CRC_EN
  logic [31:0] crc, crc_cap;
  logic        byte_pend, sfd_hit;

  assign sfd_hit = (state == HUNT) && rx_dv && rx_bit_stb && (sr_nxt == SFD);

  mac_crc32_serial u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (sfd_hit),
    .en     (store),
    .bit_in (rxd),
    .crc    (crc)
  );

  // Residue at the last byte boundary, so dribble bits do not spoil the check.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_pend <= 1'b0;
      crc_cap   <= CRC_INIT;
    end else begin
      byte_pend <= store && (bitcnt[2:0] == 3'd7);
      if (sfd_hit)        crc_cap <= CRC_INIT;
      else if (byte_pend) crc_cap <= crc;
    end
  end

  assign crc_err = (bitcnt[CNT_W-1:3] != '0) && ((byte_pend ? crc : crc_cap) != CRC_RESIDUE);
`else
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      dv_q     <= 1'b0;
      sr       <= '0;
      bitcnt   <= '0;
      word     <= '0;
      ovf      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rxfull   <= 1'b0;
      rx_busy  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      dv_q  <= rx_dv;
      wr_en <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          sr      <= '0;
          state   <= HUNT;
          rx_busy <= 1'b1;
        end
        HUNT: begin
          if (!rx_dv) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (rx_bit_stb) begin
            sr <= sr_nxt;
            if (sr_nxt == SFD) begin
              bitcnt <= '0;
              word   <= '0;
              ovf    <= 1'b0;
              state  <= DATA;
            end
          end
        end
        DATA: begin
          // A strobe coinciding with the rx_dv drop is still stored.
          if (rx_bit_stb) begin
            if (store) begin
              bitcnt <= bitcnt + CNT_W'(1);
              if (bitcnt[4:0] == 5'd31) begin
                wr_en   <= 1'b1;
                wr_addr <= word_addr;
                wr_data <= {rxd, word[30:0]};
                word    <= '0;
              end else begin
                word[bitcnt[4:0]] <= rxd;
              end
            end else begin
              ovf <= 1'b1;
            end
          end
          if (!rx_dv) state <= FLUSH;
        end
        FLUSH: begin
          wr_en <= 1'b1;
          if (bitcnt[4:0] != 5'd0) begin
            wr_addr <= word_addr;
            wr_data <= word;
            state   <= STATUS;
          end else begin
            wr_addr <= '0;
            wr_data <= status;
            state   <= HOLD;
            rx_busy <= 1'b0;
          end
        end
        STATUS: begin
          wr_en   <= 1'b1;
          wr_addr <= '0;
          wr_data <= status;
          state   <= HOLD;
          rx_busy <= 1'b0;
        end
        HOLD: begin
          if (rise && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (rx_release) begin
            rxfull <= 1'b0;
            state  <= IDLE;
          end else begin
            rxfull <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: scoreboard of expected buffer writes checked on every wr_en.
module tb_mac_rx;

  typedef logic [7:0] byteq_t[$];
  typedef bit         bitq_t[$];
  typedef struct {logic [8:0] a; logic [31:0] d;} exp_t;

  localparam int          MAXB   = 1536;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] RESID  = 32'hC704DD7B;

  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic       rx_dv = 1'b0, rxd = 1'b0, rx_bit_stb = 1'b0, rx_release = 1'b0;
  logic       wr_en, rxfull, rx_busy;
  logic [8:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0] drop_cnt;

  int   checks = 0, errors = 0;
  exp_t q[$];
  exp_t e;
  bit   chk_full = 1'b0;

  always #5 clk_i = ~clk_i;

  mac_rx #(.MAX_BYTES(MAXB), .ADDR_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_dv(rx_dv), .rxd(rxd), .rx_bit_stb(rx_bit_stb),
    .rx_release(rx_release), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rxfull(rxfull), .rx_busy(rx_busy), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (chk_full) begin
      chk_full = 1'b0;
      check("rxfull_after_status", {31'd0, rxfull}, 32'd1);
    end
    if (wr_en === 1'b1) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got addr %h data %h exp none", wr_addr, wr_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", {23'd0, wr_addr}, {23'd0, e.a});
        check("wr_data", wr_data, e.d);
        if (e.a == 9'd0) chk_full = 1'b1;
      end
    end
  end

  function automatic bitq_t to_bits(input byteq_t d);
    bitq_t b;
    foreach (d[i]) for (int j = 0; j < 8; j++) b.push_back(d[i][j]);
    return b;
  endfunction

  function automatic logic [31:0] crc_run(input bitq_t b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    bit fb;
    for (int i = 0; i < n; i++) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  task automatic expect_frame(input bitq_t bits);
    int n, nb;
    logic [31:0] w, st;
    bit crcb;
    n = (bits.size() < MAXB * 8) ? bits.size() : MAXB * 8;
    w = '0;
    for (int i = 0; i < n; i++) begin
      w[i % 32] = bits[i];
      if (i % 32 == 31) begin
        q.push_back('{a: 9'(i / 32 + 1), d: w});
        w = '0;
      end
    end
    if (n % 32 != 0) q.push_back('{a: 9'(n / 32 + 1), d: w});
    crcb = 1'b0;
`ifdef MAC_RX_CRC_EN
    nb = n - (n % 8);
    if (nb > 0) crcb = (crc_run(bits, nb) != RESID);
`else
    nb = 0;
`endif
    st = '0;
    st[11:0] = 12'(n / 8);
    st[12]   = (bits.size() > n);
    st[13]   = crcb;
    st[14]   = (n % 8) != 0;
    q.push_back('{a: 9'd0, d: st});
  endtask

  task automatic send_bit(input bit b, input bit drop);
    @(posedge clk_i); #1;
    rxd = b; rx_bit_stb = 1'b1;
    if (drop) rx_dv = 1'b0;
    @(posedge clk_i); #1;
    rx_bit_stb = 1'b0;
  endtask

  task automatic send_frame(input bitq_t bits, input bit drop_last, input bit with_sfd);
    byteq_t pre;
    bitq_t  pb;
    for (int i = 0; i < 7; i++) pre.push_back(8'h55);
    if (with_sfd) pre.push_back(8'hD5);
    pb = to_bits(pre);
    @(posedge clk_i); #1 rx_dv = 1'b1;
    repeat (2) @(posedge clk_i);
    foreach (pb[i]) send_bit(pb[i], 1'b0);
    foreach (bits[i]) send_bit(bits[i], drop_last && (i == bits.size() - 1));
    @(posedge clk_i); #1 rx_dv = 1'b0;
    repeat (4) @(posedge clk_i);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk_i);
    @(negedge clk_i);
    check(tag, q.size(), 0);
  endtask

  task automatic release_frame();
    @(posedge clk_i); #1 rx_release = 1'b1;
    @(posedge clk_i); #1 rx_release = 1'b0;
    @(negedge clk_i);
    check("rxfull_after_release", {31'd0, rxfull}, 32'd0);
  endtask

  initial begin
    byteq_t d;
    bitq_t  b;
    logic [31:0] c;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_addr", {23'd0, wr_addr}, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rxfull", {31'd0, rxfull}, 0);
    check("rst_rx_busy", {31'd0, rx_busy}, 0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    rst_i = 1'b1;

    // 8-byte frame, whole words only
    d = {}; for (int i = 1; i <= 8; i++) d.push_back(8'(i));
    b = to_bits(d);
    expect_frame(b);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_8byte");
    release_frame();

    // 5-byte frame, rx_dv drops with the last strobe
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    b = to_bits(d);
    expect_frame(b);
    send_frame(b, 1'b1, 1'b1);
    drain("drain_5byte");
    release_frame();

    // 2 bytes plus 3 dribble bits
    d = '{8'h12, 8'h34};
    b = to_bits(d);
    b.push_back(1'b1); b.push_back(1'b0); b.push_back(1'b1);
    expect_frame(b);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_dribble");
    release_frame();

    // Zero-length frame, then a frame arriving while full
    b = {};
    expect_frame(b);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_zero_len");
    d = '{8'h99, 8'h88, 8'h77};
    send_frame(to_bits(d), 1'b0, 1'b1);
    @(negedge clk_i);
    check("drop_cnt_one", {24'd0, drop_cnt}, 1);
    check("rxfull_held", {31'd0, rxfull}, 1);
    release_frame();

    d = '{8'h11, 8'h22, 8'h33};
    b = to_bits(d);
    expect_frame(b);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_after_drop");
    release_frame();

    // Preamble noise with no SFD
    @(posedge clk_i); #1 rx_dv = 1'b1;
    d = '{8'h55, 8'h55, 8'h55};
    b = to_bits(d);
    send_bit(b[0], 1'b0);
    @(negedge clk_i);
    check("noise_busy", {31'd0, rx_busy}, 1);
    for (int i = 1; i < b.size(); i++) send_bit(b[i], 1'b0);
    @(posedge clk_i); #1 rx_dv = 1'b0;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check("noise_idle_busy", {31'd0, rx_busy}, 0);
    check("noise_rxfull", {31'd0, rxfull}, 0);

    // Oversized frame: 1540 bytes, 1536 kept
    d = {}; for (int i = 0; i < 1540; i++) d.push_back(8'(i * 7 + 3));
    b = to_bits(d);
    expect_frame(b);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_oversize");
    release_frame();
    check("drop_cnt_final", {24'd0, drop_cnt}, 1);

`ifdef MAC_RX_CRC_EN
    // 56 payload bytes + valid FCS, then the same with one payload bit flipped
    d = {}; for (int i = 0; i < 56; i++) d.push_back(8'(i ^ 8'h5A));
    b = to_bits(d);
    c = crc_run(b, b.size());
    for (int i = 31; i >= 0; i--) b.push_back(~c[i]);
    expect_frame(b);
    check("crc_good_status", q[q.size()-1].d, 32'd60);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_crc_good");
    release_frame();
    b[3] = ~b[3];
    expect_frame(b);
    check("crc_bad_status", q[q.size()-1].d, 32'h0000203C);
    send_frame(b, 1'b0, 1'b1);
    drain("drain_crc_bad");
    release_frame();
`endif

    repeat (4) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_rx.md
Name: mac_rx

Overview:
- Ethernet MAC receive path, the counterpart of the MAC transmit path.
- Consumes the recovered bit stream from the PLS decoder and hunts for the SFD.
- Packs payload bits LSB-first into 32-bit words and writes them into the RX buffer (words 1..N).
- Writes a status/length word to RX buffer word 0, raises rxfull, and holds the frame until software releases it.

Parameters:
- MAX_BYTES, 1536: frame bytes stored after the SFD; bytes beyond this are discarded and flagged.
- ADDR_W, 9: RX buffer word-address width (512 words).

Ports:
- clk_i  in  1  bit-domain clock (20 MHz), single clock for the whole block.
- rst_i  in  1  reset, asynchronous, active-low.
- rx_dv  in  1  carrier/data valid from PLS, level.
- rxd  in  1  received bit, valid when rx_bit_stb=1.
- rx_bit_stb  in  1  one-cycle pulse per recovered bit.
- rx_release  in  1  one-cycle pulse from the bus side: frame consumed.
- wr_en  out  1  RX buffer write strobe.
- wr_addr  out  ADDR_W  RX buffer word address.
- wr_data  out  32  RX buffer write data.
- rxfull  out  1  frame stored and awaiting release (interrupt).
- rx_busy  out  1  high in HUNT/DATA/FLUSH/STATUS.
- drop_cnt  out  8  frames dropped while full; saturates at 255.

Behaviour:
- Reset (rst_i=0, async): state IDLE; wr_en=0, wr_addr=0, wr_data=0, rxfull=0, rx_busy=0, drop_cnt=0, internal counters and shift register cleared.
- Outputs are registered; wr_en is asserted for at most one cycle per write.
- rx_dv is sampled into dv_q; a rising edge is rx_dv=1 and dv_q=0.
- IDLE: on an rx_dv rising edge, clear sr[7:0] and go to HUNT. A frame already in progress is never captured.
- HUNT: on each strobe, sr <= {rxd, sr[7:1]}. When the new sr==8'hD5, clear bitcnt[13:0] and the word register, then go to DATA. rx_dv low returns to IDLE with no write.
- DATA, on each strobe with bitcnt < MAX_BYTES*8:
  - word[bitcnt[4:0]] <= rxd; bitcnt++.
  - If bitcnt[4:0]==31, the next cycle drives wr_en=1, wr_addr=bitcnt[13:5]+1, wr_data=completed word, and the word register clears.
- DATA, on a strobe with bitcnt >= MAX_BYTES*8: the bit is discarded and ovf is set.
- DATA, rx_dv low: go to FLUSH. rx_dv falling in the same cycle as a strobe still stores that bit.
- FLUSH:
  - If bitcnt[4:0]!=0, write the partial word (unfilled bits 0) at bitcnt[13:5]+1.
  - If bitcnt[4:0]==0, no write and no idle cycle: go straight to STATUS.
- STATUS: write word 0 as follows.
  - [11:0] bytes = bitcnt[14:3] truncated to 12 bits.
  - [12] ovf.
  - [13] crc_err.
  - [14] dribble = (bitcnt[2:0]!=0).
  - [31:15] = 0.
  - Then set rxfull=1 on the next cycle and go to HOLD.
- Zero-length frame (SFD then rx_dv drop): no data writes; status word 0 = 0; rxfull is still set.
- HOLD:
  - rxfull=1.
  - Each rx_dv rising edge increments drop_cnt (saturating at 255).
  - rx_release clears rxfull next cycle and returns to IDLE. Release and a rising edge in the same cycle: the drop is counted and the release is honoured.
- rx_release outside HOLD is ignored.
- Reset mid-frame: immediate return to IDLE. Partially written buffer contents are left as-is, with no status write.
- At most one buffer write per cycle. A word-complete write and FLUSH never coincide, because FLUSH follows the strobe cycle.

Optional Feature:
- Macro MAC_RX_CRC_EN.
- Defined:
  - A serial CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, LSB-first) runs over every bit stored in DATA, including the FCS.
  - At STATUS, the residue must equal 0xC704DD7B; otherwise status bit 13 = 1.
  - Dribble bits are excluded by checking the residue captured at the last byte boundary.
- Undefined: no CRC logic is built; status bit 13 is always 0.

Decomposition:
- Shared package mac_pkg:
  - SFD constant 8'hD5.
  - CRC polynomial and residue constants.
  - Status-word bit positions (LEN_LSB/MSB, OVF_BIT, CRC_BIT, DRIB_BIT).
  - State encoding IDLE/HUNT/DATA/FLUSH/STATUS/HOLD.
- One sub-module, mac_crc32_serial: clear, enable and bit inputs; 32-bit crc output. It is instantiated only under MAC_RX_CRC_EN.

Test Plan:
- Preamble 7x0x55 + SFD 0xD5 + bytes 0x01..0x08, then rx_dv drop -> writes addr1=0x04030201, addr2=0x08070605, then addr0=0x00000008; rxfull=1 one cycle after the addr0 write.
- 5-byte frame 0xAA 0xBB 0xCC 0xDD 0xEE -> addr1=0xDDCCBBAA, flush addr2=0x000000EE, addr0=0x00000005.
- 1540-byte frame with MAX_BYTES=1536 -> highest data write at addr 384; addr0=0x00001600 (1536 | ovf).
- Second frame while rxfull=1, then rx_release -> drop_cnt=1, buffer untouched, rxfull=0; the next frame is received normally.
- Noise 0x55 x3 then rx_dv drop without SFD -> no writes, state IDLE, rxfull=0.
- MAC_RX_CRC_EN: 60-byte frame with correct FCS -> addr0 bit13=0; flip one payload bit -> bit13=1.
